// File: rtl/convolution_procesor_div.sv
// rtl/convolution_procesor_div.sv - iterative signed restoring divider for scaling convolution sums
module convolution_procesor_div #(
  parameter int DATA_WIDTH_N = 22,
  parameter int DATA_WIDTH_D = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH_N-1:0] dividend,
  input  logic [DATA_WIDTH_D-1:0] divisor,
  output logic [DATA_WIDTH_N-1:0] quotient,
  output logic [DATA_WIDTH_D-1:0] remainder,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int N  = DATA_WIDTH_N;
  localparam int D  = DATA_WIDTH_D;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic [CW-1:0]        count_q;
  logic [N-1:0]         qreg_q;
  logic [D-1:0]         abs_d_q;
  logic [D:0]           rem_q;
  logic signed [N-1:0]  dvd_q;
  logic                 sign_n_q, sign_d_q;
  logic [N-1:0]         abs_n_in;
  logic [D-1:0]         abs_d_in;
  logic [D+1:0]         shifted, trial;

  // Magnitudes as unsigned so the most-negative operand is represented exactly
  assign abs_n_in = dividend[N-1] ? -dividend : dividend;
  assign abs_d_in = divisor[D-1]  ? -divisor  : divisor;

  // qreg_q doubles as the dividend shift register: its MSB feeds the partial remainder
  assign shifted = {rem_q, qreg_q[N-1]};
  assign trial   = shifted - {2'b00, abs_d_q};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC:    if (count_q == CW'(1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      qreg_q      <= '0;
      abs_d_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            qreg_q      <= abs_n_in;
            abs_d_q     <= abs_d_in;
            rem_q       <= '0;
            dvd_q       <= dividend;
            sign_n_q    <= dividend[N-1];
            sign_d_q    <= divisor[D-1];
            count_q     <= CW'(N);
            busy        <= 1'b1;
            div_by_zero <= (divisor == '0);
            overflow    <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
          end
        end
        CALC: begin
          count_q <= count_q - CW'(1);
          if (!trial[D+1]) begin
            rem_q  <= trial[D:0];
            qreg_q <= {qreg_q[N-2:0], 1'b1};
          end else begin
            rem_q  <= shifted[D:0];
            qreg_q <= {qreg_q[N-2:0], 1'b0};
          end
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          // Zero divisor saturates toward the dividend's sign and passes the dividend through
          if (abs_d_q == '0) begin
            quotient  <= sign_n_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
            remainder <= D'(dvd_q);
          end else begin
            quotient  <= (sign_n_q ^ sign_d_q) ? -qreg_q : qreg_q;
            remainder <= sign_n_q ? -rem_q[D-1:0] : rem_q[D-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_convolution_procesor_div.sv
// tb/tb_convolution_procesor_div.sv - scoreboard bench for convolution_procesor_div
module tb_convolution_procesor_div;

  localparam int N = 22;
  localparam int D = 22;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [D-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [D-1:0] remainder;
  logic         busy, done, div_by_zero, overflow;

  convolution_procesor_div #(.DATA_WIDTH_N(N), .DATA_WIDTH_D(D)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] q;
    logic [D-1:0] r;
    logic         dbz;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  initial forever begin
    @(negedge clk);
    if (done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(m_e.q));
        chk("remainder", 32'(remainder), 32'(m_e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_e.dbz));
        chk("overflow", 32'(overflow), 32'(m_e.ovf));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("latency", 32'(cyc), 32'(m_e.due));
      end
    end
  end

  // Issued at a negedge; accepted on the next posedge; done seen 24 negedges later
  task automatic issue(input logic [N-1:0] a, input logic [D-1:0] b,
                       input logic [N-1:0] q, input logic [D-1:0] r,
                       input logic dbz, input logic ovf);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.due = cyc + 24;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [D-1:0] b,
                     input logic [N-1:0] q, input logic [D-1:0] r,
                     input logic dbz, input logic ovf);
    issue(a, b, q, r, dbz, ovf);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", {28'd0, busy, done, div_by_zero, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(22'd100, 22'd7, 22'd14, 22'd2, 1'b0, 1'b0);
    run(-22'sd100, 22'd7, -22'sd14, -22'sd2, 1'b0, 1'b0);
    run(22'd100, -22'sd7, -22'sd14, 22'd2, 1'b0, 1'b0);
    run(-22'sd100, -22'sd7, 22'd14, -22'sd2, 1'b0, 1'b0);

    run(22'd5, 22'd0, 22'h1FFFFF, 22'd5, 1'b1, 1'b0);
    chk("dbz_sticky", 32'(div_by_zero), 32'd1);
    run(-22'sd5, 22'd0, 22'h200000, -22'sd5, 1'b1, 1'b0);

    run(22'h200000, 22'h3FFFFF, 22'h200000, 22'd0, 1'b0, 1'b1);
    issue(22'd6, 22'd3, 22'd2, 22'd0, 1'b0, 1'b0);
    chk("ovf_cleared_on_accept", 32'(overflow), 32'd0);
    wait_done();
    @(negedge clk);

    run(22'd0, 22'd5, 22'd0, 22'd0, 1'b0, 1'b0);
    run(22'd3, 22'd100, 22'd0, 22'd3, 1'b0, 1'b0);
    run(22'd1000, 22'h200000, 22'd0, 22'd1000, 1'b0, 1'b0);
    run(22'h200000, 22'h200000, 22'd1, 22'd0, 1'b0, 1'b0);

    // Start while busy is dropped; a start in the done cycle is taken
    issue(22'd100, 22'd7, 22'd14, 22'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 22'd50; divisor = 22'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(22'd9, 22'd3, 22'd3, 22'd0, 1'b0, 1'b0);
    chk("done_one_cycle", 32'(done), 32'd0);
    wait_done();
    @(negedge clk);

    // Asynchronous reset mid-operation discards the result
    start = 1'b1; dividend = 22'd100; divisor = 22'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_quotient", 32'(quotient), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_remainder", 32'(remainder), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    run(22'd9, 22'd2, 22'd4, 22'd1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
